// File: rtl/scmi_db_pkg.sv
// Shared types and defaults for the SCMI doorbell arbiter.
package scmi_db_pkg;

    typedef enum logic [1:0] {IDLE, NOTIFY, SERVICE} db_state_e;

    localparam int NUM_CH_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

    // Next round-robin position after channel v, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin first-one finder: returns the first set request
// bit at or after ptr, wrapping modulo NUM_CH.
module rr_prio_pick #(
    parameter int NUM_CH = 8,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              valid,
    output logic [ID_W-1:0]   id
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest position back to ptr so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_CH);
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/scmi_db_arbiter.sv
// Latches SCMI doorbell edges, arbitrates them round-robin and presents one
// channel at a time to the PMS core. Define SCMI_DB_TIMEOUT_EN for a service watchdog.
module scmi_db_arbiter
    import scmi_db_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int ID_W        = $clog2(NUM_CH),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] db_irq_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic              irq_o,
    output logic [ID_W-1:0]   irq_id_o,
    input  logic              irq_ack_i,
    input  logic              done_i,
    input  logic [ID_W-1:0]   done_id_i,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] overrun_o,
    input  logic [NUM_CH-1:0] overrun_clr_i,
    output logic              busy_o,
    output logic              err_o
);

    db_state_e         state;
    logic [NUM_CH-1:0] db_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] overrun_q;
    logic [ID_W-1:0]   rr_ptr;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] ov_set;
    logic [NUM_CH-1:0] eligible;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   next_ptr;
    logic              ack_fire;
    logic              done_ok;

    assign rise     = db_irq_i & ~db_q;
    assign ack_fire = (state == NOTIFY) && irq_ack_i;
    assign done_ok  = done_i && (done_id_i == irq_id_o);
    assign eligible = pending_q & ~mask_i;
    assign next_ptr = ID_W'(wrap_inc(32'(irq_id_o), NUM_CH));

    always_comb begin
        ack_clr           = '0;
        ack_clr[irq_id_o] = ack_fire;
    end

    // A rise coinciding with its own ack-clear simply re-arms pending; it is not an overrun.
    assign ov_set = rise & pending_q & ~ack_clr;

    rr_prio_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .id    (pick_id)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q      <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            db_q      <= db_irq_i;
            pending_q <= (pending_q & ~ack_clr) | rise;
            overrun_q <= (overrun_q & ~overrun_clr_i) | ov_set;
        end
    end

`ifdef SCMI_DB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
            err_o    <= 1'b0;
`ifdef SCMI_DB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            // Stray completions outside SERVICE are flagged; SERVICE overrides below.
            err_o <= done_i;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        irq_id_o <= pick_id;
                        irq_o    <= 1'b1;
                        state    <= NOTIFY;
                    end
                end
                NOTIFY: begin
                    if (irq_ack_i) begin
                        irq_o  <= 1'b0;
                        state  <= SERVICE;
`ifdef SCMI_DB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                SERVICE: begin
                    if (done_ok) begin
                        err_o  <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
`ifdef SCMI_DB_TIMEOUT_EN
                        // to_cnt counts completed SERVICE cycles; this is the last allowed one.
                        if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            err_o  <= 1'b1;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    irq_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_scmi_db_arbiter.sv
// Self-checking bench for scmi_db_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the doorbell rules.
module tb_scmi_db_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  db_irq = '0;
    logic [N-1:0]  mask = '0;
    logic          irq;
    logic [IW-1:0] irq_id;
    logic          irq_ack = 1'b0;
    logic          done = 1'b0;
    logic [IW-1:0] done_id = '0;
    logic [N-1:0]  pending;
    logic [N-1:0]  overrun;
    logic [N-1:0]  ov_clr = '0;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    scmi_db_arbiter #(
        .NUM_CH      (N),
        .ID_W        (IW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .db_irq_i      (db_irq),
        .mask_i        (mask),
        .irq_o         (irq),
        .irq_id_o      (irq_id),
        .irq_ack_i     (irq_ack),
        .done_i        (done),
        .done_id_i     (done_id),
        .pending_o     (pending),
        .overrun_o     (overrun),
        .overrun_clr_i (ov_clr),
        .busy_o        (busy),
        .err_o         (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 = nothing announced, 1 = announced to core, 2 = core working on m_id.
    logic [N-1:0] m_pend, m_ovr, m_dbq;
    int           m_phase, m_id, m_ptr, m_svc;
    bit           m_err;

    task automatic m_reset();
        m_pend = '0; m_ovr = '0; m_dbq = '0;
        m_phase = 0; m_id = 0; m_ptr = 0; m_svc = 0; m_err = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++)
            if (elig[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_clock();
        logic [N-1:0] rise, n_pend, n_ovr;
        bit ack_hit;
        int p;
        rise    = db_irq & ~m_dbq;
        n_pend  = m_pend;
        n_ovr   = m_ovr & ~ov_clr;
        ack_hit = (m_phase == 1) && irq_ack;
        if (ack_hit) n_pend[m_id] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                if (m_pend[i] && !(ack_hit && i == m_id)) n_ovr[i] = 1'b1;
                n_pend[i] = 1'b1;
            end
        end
        m_err = 1'b0;
        if (m_phase == 0) begin
            p = pick(m_pend & ~mask, m_ptr);
            if (p >= 0) begin m_id = p; m_phase = 1; end
            if (done) m_err = 1'b1;
        end else if (m_phase == 1) begin
            if (ack_hit) begin m_phase = 2; m_svc = 0; end
            if (done) m_err = 1'b1;
        end else begin
            m_svc++;
            if (done && int'(done_id) == m_id) begin
                m_ptr = (m_id + 1) % N;
                m_phase = 0;
            end else begin
                if (done) m_err = 1'b1;
`ifdef SCMI_DB_TIMEOUT_EN
                if (m_svc == TO) begin
                    m_err = 1'b1;
                    m_ptr = (m_id + 1) % N;
                    m_phase = 0;
                end
`endif
            end
        end
        m_pend = n_pend;
        m_ovr  = n_ovr;
        m_dbq  = db_irq;
    endtask

    task automatic cmp_all();
        check_eq("irq_o", irq, (m_phase == 1));
        check_eq("irq_id_o", irq_id, m_id);
        check_eq("busy_o", busy, (m_phase != 0));
        check_eq("err_o", err, m_err);
        check_eq("pending_o", pending, m_pend);
        check_eq("overrun_o", overrun, m_ovr);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        #1;
        cmp_all();
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done(input int id);
        done = 1'b1; done_id = IW'(id); cyc(); done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        db_irq = '0; mask = '0; irq_ack = 1'b0; done = 1'b0; done_id = '0; ov_clr = '0;
        m_reset();
        #1;
        check_eq("rst_irq", irq, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_id", irq_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_irq(input int max_cyc);
        int k;
        k = 0;
        while (!irq && k < max_cyc) begin cyc(); k++; end
        check_eq("irq_seen", irq, 1);
    endtask

    task automatic serve(input int exp_id);
        wait_irq(6);
        check_eq("serve_id", irq_id, exp_id);
        pulse_ack();
        check_eq("serve_busy", busy, 1);
        check_eq("serve_irq_low", irq, 0);
        pulse_done(exp_id);
        check_eq("serve_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        m_reset();

        // Single doorbell on channel 3.
        do_reset();
        db_irq[3] = 1'b1;
        cyc();
        check_eq("ch3_pending", pending[3], 1);
        check_eq("ch3_no_irq_yet", irq, 0);
        cyc();
        check_eq("ch3_irq", irq, 1);
        check_eq("ch3_id", irq_id, 3);
        db_irq = '0;
        pulse_ack();
        check_eq("ch3_cleared", pending[3], 0);
        check_eq("ch3_busy", busy, 1);
        pulse_done(3);
        check_eq("ch3_done", busy, 0);

        // Round-robin ordering.
        do_reset();
        db_irq = 8'b0110_0010;
        cyc();
        db_irq = '0;
        serve(1); serve(5); serve(6);
        db_irq = 8'b0100_0010;
        cyc();
        db_irq = '0;
        serve(1); serve(6);

        // Overrun: two edges on channel 2 before the ack.
        do_reset();
        db_irq[2] = 1'b1; cyc();
        db_irq[2] = 1'b0; cyc();
        db_irq[2] = 1'b1; cyc();
        check_eq("ovr_set", overrun[2], 1);
        check_eq("ovr_irq", irq, 1);
        db_irq = '0;
        pulse_ack();
        pulse_done(2);
        repeat (4) cyc();
        check_eq("ovr_single_notify", irq, 0);
        ov_clr[2] = 1'b1; cyc(); ov_clr = '0;
        check_eq("ovr_cleared", overrun[2], 0);

        // Masked channel stays latched until unmasked.
        do_reset();
        mask[4] = 1'b1;
        db_irq[4] = 1'b1;
        repeat (3) cyc();
        db_irq = '0;
        check_eq("mask_no_irq", irq, 0);
        check_eq("mask_pending", pending[4], 1);
        mask = '0;
        cyc(); cyc();
        check_eq("unmask_irq", irq, 1);
        check_eq("unmask_id", irq_id, 4);

        // Wrong-id completion, then correct one; then a stray done in IDLE.
        do_reset();
        db_irq[0] = 1'b1; cyc(); db_irq = '0;
        wait_irq(4);
        check_eq("bad_done_id", irq_id, 0);
        pulse_ack();
        pulse_done(7);
        check_eq("bad_done_err", err, 1);
        check_eq("bad_done_busy", busy, 1);
        cyc();
        check_eq("bad_done_err_pulse", err, 0);
        pulse_done(0);
        check_eq("good_done_idle", busy, 0);
        pulse_done(3);
        check_eq("stray_done_err", err, 1);

`ifdef SCMI_DB_TIMEOUT_EN
        // Service watchdog.
        do_reset();
        db_irq[2] = 1'b1; cyc(); db_irq = '0;
        wait_irq(4);
        pulse_ack();
        k = 0;
        while (!err && k < 40) begin cyc(); k++; end
        check_eq("timeout_cycles", k, TO);
        check_eq("timeout_idle", busy, 0);
`endif

        // Reset while notifying.
        do_reset();
        db_irq[5] = 1'b1; cyc(); cyc();
        check_eq("pre_reset_irq", irq, 1);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            db_irq = db_irq ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 31) == 0) mask = N'($urandom & $urandom);
            irq_ack = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
            if (busy && !irq) begin
                done    = ($urandom_range(0, 4) == 0);
                done_id = ($urandom_range(0, 9) == 0) ? IW'($urandom) : irq_id;
            end else begin
                done    = ($urandom_range(0, 60) == 0);
                done_id = IW'($urandom);
            end
            ov_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scmi_db_arbiter.md
Name: scmi_db_arbiter

Overview:
- Collects SCMI doorbell interrupts from NUM_CH external agents and latches them as pending.
- Arbitrates the pending doorbells round-robin.
- Presents exactly one doorbell at a time to the PMS core as a single interrupt plus channel id.
- Holds that channel in service until the core signals completion. Sits between the external interrupt lines of pms_top and the core's event/interrupt input.

Parameters:
- NUM_CH, 8, number of doorbell channels (≤ pms_top_pkg::NUM_EXT_INTERRUPTS).
- ID_W, $clog2(NUM_CH), width of channel id.
- TIMEOUT_CYC, 100000, service watchdog limit in cycles (used only with SCMI_DB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- db_irq_i  in  NUM_CH  doorbell lines, already synchronous to clk_i; a rising edge means a new message.
- mask_i  in  NUM_CH  1 = channel excluded from arbitration (it still latches).
- irq_o  out  1  interrupt to core.
- irq_id_o  out  ID_W  channel being notified/serviced.
- irq_ack_i  in  1  core claims the interrupt (1-cycle pulse).
- done_i  in  1  core finished the channel (1-cycle pulse).
- done_id_i  in  ID_W  channel id accompanying done_i.
- pending_o  out  NUM_CH  latched pending vector.
- overrun_o  out  NUM_CH  sticky: an edge arrived while that channel was already pending.
- overrun_clr_i  in  NUM_CH  clears the matching overrun bits.
- busy_o  out  1  state != IDLE.
- err_o  out  1  1-cycle pulse on an illegal done or timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, db_q 0.
- Edge detection:
  - db_q <= db_irq_i; rise = db_irq_i & ~db_q.
  - rise[i] sets pending[i] on the next edge.
  - rise[i] with pending[i] already 1 also sets overrun[i].
  - rise[i] in the same cycle as that bit's ack-clear: the set wins, pending stays 1, no overrun.
  - overrun_clr_i[i] with a simultaneous overrun set: the set wins.
- Arbitration:
  - eligible = pending & ~mask_i.
  - Grant the first set bit at or after rr_ptr, wrapping modulo NUM_CH.
- FSM states: IDLE, NOTIFY, SERVICE.
- IDLE: when eligible != 0, register the granted id into irq_id_o and go to NOTIFY.
- NOTIFY:
  - irq_o = 1 (registered) for the whole state.
  - mask_i is not re-evaluated, so the interrupt is never withdrawn.
  - On irq_ack_i: clear pending[irq_id_o] and go to SERVICE.
- SERVICE:
  - irq_o = 0; irq_id_o is held.
  - On done_i with done_id_i == irq_id_o: rr_ptr <= (irq_id_o+1) mod NUM_CH, go to IDLE.
  - On done_i with any other id: err_o pulse, state unchanged.
- Stray irq_ack_i outside NOTIFY: ignored.
- Stray done_i outside SERVICE: ignored, err_o pulses.
- A new edge on the channel in SERVICE re-sets pending; that channel is re-arbitrated after done, behind the other channels per round-robin.
- Latency:
  - Edge sampled in cycle t → pending visible t+1 → irq_o high t+2 (from IDLE).
  - done in cycle t → IDLE at t+1 → next irq_o at t+2.
- Masked pending bits stay latched; unmasking makes them eligible in the next IDLE cycle.
- Asynchronous reset mid-operation drops irq_o immediately and clears all state; no partial service is resumed.

Optional Feature:
- Macro: SCMI_DB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) is cleared on entering SERVICE and increments each SERVICE cycle.
  - On reaching TIMEOUT_CYC: err_o pulse, rr_ptr advances, go to IDLE (channel force-released).
  - A done_i in the same cycle as the timeout is treated as a normal completion: no err_o.
- Undefined: no counter; SERVICE waits indefinitely.

Decomposition:
- Package scmi_db_pkg holds:
  - the typedef enum logic [1:0] {IDLE, NOTIFY, SERVICE} db_state_e;
  - the default constants for NUM_CH and TIMEOUT_CYC.
- Sub-module rr_prio_pick (combinational round-robin first-one finder):
  - inputs: request vector, pointer;
  - outputs: valid, id.
  - The FSM and latches live in the top.

Test Plan:
- Single doorbell: rise on ch3 → irq_o=1, irq_id_o=3 two cycles later → ack → pending[3]=0, busy_o=1 → done id 3 → busy_o=0.
- Round-robin: ch1, ch5 and ch6 rise together, rr_ptr=0 → served in order 1, 5, 6; then ch1 and ch6 rise again after the 6 completes → served 1, then 6.
- Overrun: ch2 rises twice before ack → overrun_o[2]=1 and a single notification → overrun_clr_i[2] clears it.
- Mask: mask_i[4]=1 with ch4 rising → no irq_o, pending_o[4]=1 → unmask → irq_o with id 4 within 2 cycles.
- Bad done: service ch0, done_i with id 7 → err_o pulse, still in SERVICE → done id 0 → IDLE.
- Timeout (SCMI_DB_TIMEOUT_EN, TIMEOUT_CYC=16): ack ch2 with no done → err_o at exactly 16 SERVICE cycles, busy_o=0 the cycle after.
- Reset mid-NOTIFY: rst_ni low → irq_o=0, pending_o=0 asynchronously.
